// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and data access. Data wins by default; a streak limit guarantees fetch
// progress. Optional macro ARB_TIMEOUT_EN adds a WAIT-state timeout with err_o.
module mem_port_arbiter #(
  parameter int XLEN           = 32,
  parameter int MAX_DSTREAK    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ireq_i,
  input  logic [XLEN-1:0] iaddr_i,
  output logic            igrant_o,
  output logic            irvalid_o,
  output logic [XLEN-1:0] irdata_o,
  input  logic            dreq_i,
  input  logic            dwe_i,
  input  logic [XLEN-1:0] daddr_i,
  input  logic [XLEN-1:0] dwdata_i,
  output logic            dgrant_o,
  output logic            drvalid_o,
  output logic [XLEN-1:0] drdata_o,
  output logic            mreq_o,
  output logic            mwe_o,
  output logic [XLEN-1:0] maddr_o,
  output logic [XLEN-1:0] mwdata_o,
  input  logic            mready_i,
  input  logic            mrvalid_i,
  input  logic [XLEN-1:0] mrdata_i,
`ifdef ARB_TIMEOUT_EN
  output logic            err_o,
`endif
  output logic            busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_src;      // 1 = data, 0 = instruction
  logic            r_first;    // first ISSUE cycle of a transaction
  logic            r_mwe;
  logic [XLEN-1:0] r_maddr;
  logic [XLEN-1:0] r_mwdata;
  logic [XLEN-1:0] r_irdata;
  logic [XLEN-1:0] r_drdata;
  logic            r_irvalid;
  logic            r_drvalid;
  logic [3:0]      r_dstreak;

  logic            w_start;
  logic            w_sel_i;
  logic            w_sel_d;
  logic            w_capture;
  logic            w_timeout;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_wcnt;
  logic          r_err;
`endif

  assign w_start = (r_state == IDLE) && (ireq_i || dreq_i);
  assign w_sel_i = ireq_i && (!dreq_i || (r_dstreak == 4'(MAX_DSTREAK)));
  assign w_sel_d = dreq_i && !w_sel_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and capture/timeout strobes
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE:  if (ireq_i || dreq_i) w_next = ISSUE;
      ISSUE: begin
        if (mready_i) begin
          if (mrvalid_i) begin
            w_capture = 1'b1;
            w_next    = IDLE;
          end else begin
            w_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (mrvalid_i) begin
          w_capture = 1'b1;
          w_next    = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_wcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
`endif
      end
      default: w_next = IDLE;
    endcase
  end

  // Request latching, streak tracking and response capture
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_src     <= 1'b0;
      r_first   <= 1'b0;
      r_mwe     <= 1'b0;
      r_maddr   <= '0;
      r_mwdata  <= '0;
      r_irdata  <= '0;
      r_drdata  <= '0;
      r_irvalid <= 1'b0;
      r_drvalid <= 1'b0;
      r_dstreak <= '0;
    end else begin
      r_first   <= 1'b0;
      r_irvalid <= 1'b0;
      r_drvalid <= 1'b0;
      if (w_start) begin
        r_src    <= w_sel_d;
        r_first  <= 1'b1;
        r_mwe    <= w_sel_d & dwe_i;
        r_maddr  <= w_sel_d ? daddr_i  : iaddr_i;
        r_mwdata <= w_sel_d ? dwdata_i : '0;
        if (w_sel_d && ireq_i) begin
          if (r_dstreak != 4'(MAX_DSTREAK)) r_dstreak <= r_dstreak + 4'd1;
        end else begin
          r_dstreak <= '0;
        end
      end
      if (w_capture || w_timeout) begin
        if (r_src) begin
          r_drdata  <= w_timeout ? '0 : mrdata_i;
          r_drvalid <= 1'b1;
        end else begin
          r_irdata  <= w_timeout ? '0 : mrdata_i;
          r_irvalid <= 1'b1;
        end
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  // WAIT-cycle counter (cleared while issuing) and error pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (r_state == WAIT) r_wcnt <= r_wcnt + 1'b1;
      else                 r_wcnt <= '0;
    end
  end
  assign err_o = r_err;
`endif

  assign igrant_o  = (r_state == ISSUE) && r_first && !r_src;
  assign dgrant_o  = (r_state == ISSUE) && r_first &&  r_src;
  assign mreq_o    = (r_state == ISSUE);
  assign mwe_o     = r_mwe;
  assign maddr_o   = r_maddr;
  assign mwdata_o  = r_mwdata;
  assign irvalid_o = r_irvalid;
  assign irdata_o  = r_irdata;
  assign drvalid_o = r_drvalid;
  assign drdata_o  = r_drdata;
  assign busy_o    = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (default parameters).
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ireq_i = 1'b0;
  logic [31:0] iaddr_i = '0;
  logic        igrant_o, irvalid_o;
  logic [31:0] irdata_o;
  logic        dreq_i = 1'b0, dwe_i = 1'b0;
  logic [31:0] daddr_i = '0, dwdata_i = '0;
  logic        dgrant_o, drvalid_o;
  logic [31:0] drdata_o;
  logic        mreq_o, mwe_o;
  logic [31:0] maddr_o, mwdata_o;
  logic        mready_i = 1'b0, mrvalid_i = 1'b0;
  logic [31:0] mrdata_i = '0;
  logic        busy_o;
`ifdef ARB_TIMEOUT_EN
  logic        err_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.XLEN(32), .MAX_DSTREAK(4), .TIMEOUT_CYCLES(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ireq_i(ireq_i), .iaddr_i(iaddr_i), .igrant_o(igrant_o),
    .irvalid_o(irvalid_o), .irdata_o(irdata_o),
    .dreq_i(dreq_i), .dwe_i(dwe_i), .daddr_i(daddr_i), .dwdata_i(dwdata_i),
    .dgrant_o(dgrant_o), .drvalid_o(drvalid_o), .drdata_o(drdata_o),
    .mreq_o(mreq_o), .mwe_o(mwe_o), .maddr_o(maddr_o), .mwdata_o(mwdata_o),
    .mready_i(mready_i), .mrvalid_i(mrvalid_i), .mrdata_i(mrdata_i),
`ifdef ARB_TIMEOUT_EN
    .err_o(err_o),
`endif
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    ireq_i = 0; dreq_i = 0; dwe_i = 0; mready_i = 0; mrvalid_i = 0;
    rst_i = 1;
    #12;
    rst_i = 0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string seq;
    int ng;
    // ---------------- reset state
    mrvalid_i = 1; mrdata_i = 32'hFFFF_FFFF; ireq_i = 1; dreq_i = 1;
    #23;
    check("rst_igrant", igrant_o, 0);
    check("rst_dgrant", dgrant_o, 0);
    check("rst_irvalid", irvalid_o, 0);
    check("rst_drvalid", drvalid_o, 0);
    check("rst_mreq", mreq_o, 0);
    check("rst_mwe", mwe_o, 0);
    check("rst_maddr", maddr_o, 0);
    check("rst_mwdata", mwdata_o, 0);
    check("rst_irdata", irdata_o, 0);
    check("rst_drdata", drdata_o, 0);
    check("rst_busy", busy_o, 0);
    do_reset();

    // ---------------- lone instruction read
    ireq_i = 1; iaddr_i = 32'h100; mready_i = 1;
    tick();
    check("li_igrant", igrant_o, 1);
    check("li_dgrant", dgrant_o, 0);
    check("li_mreq", mreq_o, 1);
    check("li_maddr", maddr_o, 32'h100);
    check("li_mwe", mwe_o, 0);
    ireq_i = 0;
    tick();
    check("li_wait_mreq", mreq_o, 0);
    check("li_wait_igrant", igrant_o, 0);
    check("li_wait_busy", busy_o, 1);
    mrvalid_i = 1; mrdata_i = 32'h0050_0093;
    tick();
    mrvalid_i = 0;
    check("li_irvalid", irvalid_o, 1);
    check("li_irdata", irdata_o, 32'h0050_0093);
    check("li_drvalid", drvalid_o, 0);
    check("li_busy", busy_o, 0);
    tick();
    check("li_irvalid_pulse", irvalid_o, 0);

    // ---------------- simultaneous requests
    do_reset();
    ireq_i = 1; iaddr_i = 32'h300;
    dreq_i = 1; dwe_i = 1; daddr_i = 32'h2000; dwdata_i = 32'hDEAD_BEEF;
    mready_i = 1;
    tick();
    check("sim_dgrant", dgrant_o, 1);
    check("sim_igrant", igrant_o, 0);
    check("sim_mwe", mwe_o, 1);
    check("sim_maddr", maddr_o, 32'h2000);
    check("sim_mwdata", mwdata_o, 32'hDEAD_BEEF);
    dreq_i = 0;
    tick();
    mrvalid_i = 1; mrdata_i = 32'h1234;
    tick();
    check("sim_drvalid", drvalid_o, 1);
    check("sim_drdata", drdata_o, 32'h1234);
    mrdata_i = 32'h77;
    tick();
    check("sim_igrant2", igrant_o, 1);
    check("sim_maddr2", maddr_o, 32'h300);
    check("sim_mwe2", mwe_o, 0);
    ireq_i = 0;
    tick();
    mrvalid_i = 0;
    check("sim_irvalid", irvalid_o, 1);
    check("sim_irdata", irdata_o, 32'h77);
    check("sim_drdata_kept", drdata_o, 32'h1234);

    // ---------------- starvation limit (same-cycle responses, 2 cycles/txn)
    do_reset();
    ireq_i = 1; iaddr_i = 32'h400; dreq_i = 1; dwe_i = 0; daddr_i = 32'h500;
    mready_i = 1; mrvalid_i = 1; mrdata_i = 32'h9;
    seq = "DDDDIDDDDI";
    ng = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (seq[i] == "D") begin
        check($sformatf("starve_d%0d", i), {dgrant_o, igrant_o}, 2'b10);
        ng++;
      end else begin
        check($sformatf("starve_i%0d", i), {dgrant_o, igrant_o}, 2'b01);
      end
      tick();
    end
    check("starve_dcount", ng, 8);
    ireq_i = 0; dreq_i = 0; mrvalid_i = 0;

    // ---------------- backpressure, then reset in WAIT
    do_reset();
    dreq_i = 1; dwe_i = 0; daddr_i = 32'h44; dwdata_i = 32'h99; mready_i = 0;
    ng = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin dreq_i = 0; daddr_i = 32'hBAD; dwdata_i = 32'hBAD; end
      ng += int'(dgrant_o);
      check($sformatf("bp_mreq%0d", i), mreq_o, 1);
      check($sformatf("bp_maddr%0d", i), maddr_o, 32'h44);
      check($sformatf("bp_mwdata%0d", i), mwdata_o, 32'h99);
      check($sformatf("bp_busy%0d", i), busy_o, 1);
    end
    check("bp_grant_count", ng, 1);
    mready_i = 1;
    tick();
    check("bp_wait_mreq", mreq_o, 0);
    check("bp_wait_busy", busy_o, 1);
    rst_i = 1;
    #2;
    check("rw_busy", busy_o, 0);
    check("rw_maddr", maddr_o, 0);
    check("rw_mwdata", mwdata_o, 0);
    check("rw_mwe", mwe_o, 0);
    #2;
    rst_i = 0;
    mrvalid_i = 1; mrdata_i = 32'hAB;
    tick();
    check("rw_drvalid", drvalid_o, 0);
    check("rw_busy2", busy_o, 0);
    mrvalid_i = 0;
    tick();
    check("rw_drvalid2", drvalid_o, 0);
    check("rw_drdata", drdata_o, 0);

    // ---------------- same-cycle accept and response
    dreq_i = 1; dwe_i = 0; daddr_i = 32'h80; mready_i = 1;
    mrvalid_i = 1; mrdata_i = 32'h55;
    tick();
    check("sc_dgrant", dgrant_o, 1);
    dreq_i = 0;
    tick();
    mrvalid_i = 0;
    check("sc_drvalid", drvalid_o, 1);
    check("sc_drdata", drdata_o, 32'h55);
    check("sc_busy", busy_o, 0);
    tick();
    check("sc_drvalid_pulse", drvalid_o, 0);

`ifdef ARB_TIMEOUT_EN
    // ---------------- timeout abort
    do_reset();
    dreq_i = 1; daddr_i = 32'h60; mready_i = 1; mrvalid_i = 0;
    tick();
    dreq_i = 0;
    tick();
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i < 64) begin
        if (i == 63) begin
          check("to_err_early", err_o, 0);
          check("to_drvalid_early", drvalid_o, 0);
        end
      end else begin
        check("to_err", err_o, 1);
        check("to_drvalid", drvalid_o, 1);
        check("to_drdata", drdata_o, 0);
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
